// File: rtl/char_flush_scanner_if.sv
// Handshake and pixel bus between the character-cell scanner, its glyph LUT
// and the VGA plot adapter.
interface char_flush_scanner_if;
   logic       start;
   logic [7:0] origin_x;
   logic [7:0] origin_y;
   logic       stall;
   logic [5:0] glyph_colour;
   logic       glyph_en;
   logic [7:0] flush_x;
   logic [7:0] flush_y;
   logic [7:0] org_x;
   logic [7:0] org_y;
   logic [7:0] vga_x;
   logic [7:0] vga_y;
   logic [5:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   modport master (
      output start, origin_x, origin_y, stall, glyph_colour, glyph_en,
      input  flush_x, flush_y, org_x, org_y, vga_x, vga_y, vga_colour,
             vga_plot, busy, done
   );

   modport slave (
      input  start, origin_x, origin_y, stall, glyph_colour, glyph_en,
      output flush_x, flush_y, org_x, org_y, vga_x, vga_y, vga_colour,
             vga_plot, busy, done
   );
endinterface

// File: rtl/char_flush_scanner.sv
// Sweeps one BOX_W x BOX_H character cell through the glyph LUT and emits VGA plot
// strobes one cycle later. Define CHAR_SCAN_CLEAR_BG_EN to repaint background pixels too.
module char_flush_scanner #(
   parameter int         BOX_W     = 8,
   parameter int         BOX_H     = 10,
   parameter logic [5:0] BG_COLOUR = 6'b000000
) (
   input  logic               clk,
   input  logic               reset,
   char_flush_scanner_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [7:0] LAST_X = 8'(BOX_W - 1);
   localparam logic [7:0] LAST_Y = 8'(BOX_H - 1);

   state_t     state_reg;
   logic [7:0] offset_x_reg;
   logic [7:0] offset_y_reg;
   logic [7:0] flush_x_reg;
   logic [7:0] flush_y_reg;
   logic [7:0] org_x_reg;
   logic [7:0] org_y_reg;
   logic [7:0] vga_x_reg;
   logic [7:0] vga_y_reg;
   logic [5:0] vga_colour_reg;
   logic       plot_reg;
   logic       busy_reg;
   logic       done_reg;

   logic       carry_x;
   logic       carry_y;
   logic       eligible;
   logic [5:0] pix_colour;
   logic       last_addr;

   // flush = org + offset mod 256 with offset < 256, so a wrap shows up as flush < org.
   assign carry_x   = (flush_x_reg < org_x_reg);
   assign carry_y   = (flush_y_reg < org_y_reg);
   assign last_addr = (offset_x_reg == LAST_X) && (offset_y_reg == LAST_Y);

`ifdef CHAR_SCAN_CLEAR_BG_EN
   assign eligible = !carry_x && !carry_y;
`else
   assign eligible = !carry_x && !carry_y && bus.glyph_en;
`endif
   assign pix_colour = bus.glyph_en ? bus.glyph_colour : BG_COLOUR;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         offset_x_reg   <= '0;
         offset_y_reg   <= '0;
         flush_x_reg    <= '0;
         flush_y_reg    <= '0;
         org_x_reg      <= '0;
         org_y_reg      <= '0;
         vga_x_reg      <= '0;
         vga_y_reg      <= '0;
         vga_colour_reg <= '0;
         plot_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  org_x_reg    <= bus.origin_x;
                  org_y_reg    <= bus.origin_y;
                  flush_x_reg  <= bus.origin_x;
                  flush_y_reg  <= bus.origin_y;
                  offset_x_reg <= '0;
                  offset_y_reg <= '0;
                  busy_reg     <= 1'b1;
                  state_reg    <= SCAN;
               end
            end
            SCAN: begin
               if (!bus.stall) begin
                  // Capture the sample for the address presented this cycle.
                  vga_x_reg      <= flush_x_reg;
                  vga_y_reg      <= flush_y_reg;
                  vga_colour_reg <= pix_colour;
                  plot_reg       <= eligible;
                  if (last_addr) begin
                     state_reg <= DRAIN;
                  end else if (offset_x_reg == LAST_X) begin
                     offset_x_reg <= '0;
                     offset_y_reg <= offset_y_reg + 8'd1;
                     flush_x_reg  <= org_x_reg;
                     flush_y_reg  <= flush_y_reg + 8'd1;
                  end else begin
                     offset_x_reg <= offset_x_reg + 8'd1;
                     flush_x_reg  <= flush_x_reg + 8'd1;
                  end
               end
            end
            DRAIN: begin
               if (!bus.stall) begin
                  plot_reg  <= 1'b0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.flush_x    = flush_x_reg;
   assign bus.flush_y    = flush_y_reg;
   assign bus.org_x      = org_x_reg;
   assign bus.org_y      = org_y_reg;
   assign bus.vga_x      = vga_x_reg;
   assign bus.vga_y      = vga_y_reg;
   assign bus.vga_colour = vga_colour_reg;
   // Held pixel stays registered under stall and re-presents once stall drops.
   assign bus.vga_plot   = plot_reg && !bus.stall;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
endmodule

// File: tb/tb_char_flush_scanner.sv
// Directed bench for char_flush_scanner: glyph "D" LUT model, stall, screen-edge,
// restart-while-busy and mid-scan reset cases.
module tb_char_flush_scanner;
   logic clk;
   logic reset;
   char_flush_scanner_if bus ();

   char_flush_scanner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CHAR_SCAN_CLEAR_BG_EN
   localparam bit CLEAR = 1'b1;
`else
   localparam bit CLEAR = 1'b0;
`endif
   localparam logic [5:0] FG = 6'h2D;
   localparam logic [5:0] JUNK = 6'h15;
   localparam int MAXC = 200;

   int total = 0;
   int bad = 0;

   logic [21:0] obs_q[$];
   logic [21:0] exp_q[$];
   int stall_plots;
   logic busy_c1, busy_at_done;
   logic [7:0] org_at35, flush_x12, vga_x12, vga_y12;

   // Glyph "D" bitmap, bit c of a row = column c.
   function automatic logic glyph_bit(input int c, input int r);
      logic [7:0] row;
      case (r)
         1, 8:       row = 8'h1E;
         2, 7:       row = 8'h32;
         3, 4, 5, 6: row = 8'h42;
         default:    row = 8'h00;
      endcase
      if (c < 0 || c > 7) return 1'b0;
      return row[c];
   endfunction

   logic [7:0] dx, dy;
   always_comb begin
      dx = bus.flush_x - bus.org_x;
      dy = bus.flush_y - bus.org_y;
      bus.glyph_en = (dx < 8'd8 && dy < 8'd10) ? glyph_bit(int'(dx), int'(dy)) : 1'b0;
      bus.glyph_colour = bus.glyph_en ? FG : JUNK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic build_exp(input logic [7:0] ox, input logic [7:0] oy);
      int x9, y9;
      logic en;
      logic [7:0] xb, yb;
      exp_q.delete();
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 8; c++) begin
            x9 = int'(ox) + c;
            y9 = int'(oy) + r;
            en = glyph_bit(c, r);
            xb = x9[7:0];
            yb = y9[7:0];
            if (x9 < 256 && y9 < 256 && (en || CLEAR))
               exp_q.push_back({xb, yb, en ? FG : 6'b000000});
         end
      end
   endtask

   task automatic cmp_seq(input string tag);
      int n;
      chk({tag, "_len"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_pix"}, obs_q[i], exp_q[i]);
   endtask

   task automatic run_op(input logic [7:0] ox, input logic [7:0] oy,
                         input int stall_lo, input int stall_hi,
                         input int restart_at, input int reset_at,
                         output int done_cyc, output int ndone);
      obs_q.delete();
      done_cyc = -1;
      ndone = 0;
      stall_plots = 0;
      busy_at_done = 1'bx;
      @(negedge clk);
      bus.start = 1'b1;
      bus.origin_x = ox;
      bus.origin_y = oy;
      for (int c = 1; c <= MAXC; c++) begin
         @(negedge clk);
         if (c == restart_at) begin
            bus.start = 1'b1;
            bus.origin_x = 8'd0;
            bus.origin_y = 8'd0;
         end else begin
            bus.start = 1'b0;
            bus.origin_x = ox;
            bus.origin_y = oy;
         end
         bus.stall = (c >= stall_lo && c <= stall_hi);
         if (reset_at > 0 && c == reset_at) reset = 1'b1;
         if (reset_at > 0 && c == reset_at + 2) reset = 1'b0;
         #1;
         if (reset_at > 0 && c == reset_at) begin
            chk("rst_flush_x", bus.flush_x, 0);
            chk("rst_flush_y", bus.flush_y, 0);
            chk("rst_org_x", bus.org_x, 0);
            chk("rst_vga_x", bus.vga_x, 0);
            chk("rst_vga_plot", bus.vga_plot, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
         end
         if (bus.vga_plot) obs_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
         if (bus.stall && bus.vga_plot) stall_plots++;
         if (c == 1) busy_c1 = bus.busy;
         if (c == 12) begin
            flush_x12 = bus.flush_x;
            vga_x12 = bus.vga_x;
            vga_y12 = bus.vga_y;
         end
         if (c == 35) org_at35 = bus.org_x;
         if (bus.done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = c;
               busy_at_done = bus.busy;
            end
         end
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      $display("op origin=(%0d,%0d) plots=%0d done_cyc=%0d dones=%0d",
               ox, oy, obs_q.size(), done_cyc, ndone);
   endtask

   int dc, nd;

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.origin_x = 8'd0;
      bus.origin_y = 8'd0;
      bus.stall = 1'b0;
      #2;
      chk("init_flush_x", bus.flush_x, 0);
      chk("init_org_y", bus.org_y, 0);
      chk("init_vga_plot", bus.vga_plot, 0);
      chk("init_busy", bus.busy, 0);
      chk("init_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0;

      // Plain draw of "D" at (16,20).
      build_exp(8'd16, 8'd20);
      run_op(8'd16, 8'd20, -1, -1, -1, -1, dc, nd);
      chk("a_done_cyc", dc, 82);
      chk("a_ndone", nd, 1);
      chk("a_busy_c1", busy_c1, 1);
      chk("a_busy_done", busy_at_done, 0);
      chk("a_nplots", obs_q.size(), CLEAR ? 80 : 22);
      cmp_seq("a");

      // Stall cycles 10..14.
      run_op(8'd16, 8'd20, 10, 14, -1, -1, dc, nd);
      chk("b_done_cyc", dc, 87);
      chk("b_stall_plots", stall_plots, 0);
      chk("b_flush_x12", flush_x12, 17);
      chk("b_vga_x12", vga_x12, 16);
      chk("b_vga_y12", vga_y12, 21);
      cmp_seq("b");

      // Right screen edge: offsets 6,7 carry past column 255.
      build_exp(8'd250, 8'd0);
      run_op(8'd250, 8'd0, -1, -1, -1, -1, dc, nd);
      chk("c_done_cyc", dc, 82);
      chk("c_nplots", obs_q.size(), CLEAR ? 60 : 18);
      cmp_seq("c");

      // Second start while busy is ignored.
      build_exp(8'd16, 8'd20);
      run_op(8'd16, 8'd20, -1, -1, 30, -1, dc, nd);
      chk("d_org_x35", org_at35, 16);
      chk("d_ndone", nd, 1);
      chk("d_done_cyc", dc, 82);
      cmp_seq("d");

      // Reset mid-scan aborts without a done pulse.
      run_op(8'd16, 8'd20, -1, -1, -1, 40, dc, nd);
      chk("e_ndone", nd, 0);
      chk("e_busy_after", bus.busy, 0);

      // Fresh start after the abort.
      run_op(8'd16, 8'd20, -1, -1, -1, -1, dc, nd);
      chk("f_done_cyc", dc, 82);
      chk("f_ndone", nd, 1);
      cmp_seq("f");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
